prio_grant_arbiter: RTL and testbench

Sequential arbiter that shares one downstream resource among `NUM_REQ` requesters, using a one-hot priority pick with an optional round-robin rotation. It registers a one-hot grant and holds it while the owner keeps requesting, up to `MAX_HOLD` cycles, then forces release. It sits in front of the shared encoder/datapath and drives its select inputs.

---
 rtl/prio_grant_arbiter_pkg.sv | 26 ++
 rtl/prio_grant_arbiter_if.sv | 38 +++
 rtl/prio_grant_arbiter_rr_pick.sv | 48 ++++
 rtl/prio_grant_arbiter.sv | 111 +++++++++++
 tb/tb_prio_grant_arbiter.sv | 136 +++++++++++++
 5 files changed

// File: rtl/prio_grant_arbiter_pkg.sv
// rtl/prio_grant_arbiter_pkg.sv - shared types and helpers for the priority grant arbiter
// Contents:
//   state_t : FSM state encoding (ST_IDLE = 1'b0, ST_GRANT = 1'b1)
//   clog2   : index width helper, never returns less than 1
package arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Width needed to hold indices 0..value-1. The result is clamped to at least 1
    // so that a 1-bit field still exists for the degenerate small cases.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/prio_grant_arbiter_if.sv
// rtl/prio_grant_arbiter_if.sv - request/grant bundle between requesters and the arbiter
// Signals:
//   req    : level request per requester            (requester -> arbiter)
//   gnt    : registered one-hot grant, zero if idle  (arbiter -> requester)
//   gnt_id : binary index of current/last owner      (arbiter -> requester)
//   busy   : high while a grant is active            (arbiter -> requester)
//   expire : one-cycle pulse after a hold-limit end  (arbiter -> requester)
// Modports: master = requester side, slave = arbiter side.
interface prio_grant_arbiter_if
    import arb_pkg::*;
#(
    parameter int NUM_REQ = 3
);
    localparam int IDW = clog2(NUM_REQ);

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic [IDW-1:0]     gnt_id;
    logic               busy;
    logic               expire;

    modport master (
        output req,
        input  gnt,
        input  gnt_id,
        input  busy,
        input  expire
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_id,
        output busy,
        output expire
    );

endinterface

// File: rtl/prio_grant_arbiter_rr_pick.sv
// rtl/prio_grant_arbiter_rr_pick.sv - combinational winner pick, round-robin or fixed priority
// Ports:
//   req_i   : request vector
//   last_i  : index of the previous owner; search starts just above it when RR_EN=1
//   win_o   : winning index (0 when nothing requests)
//   valid_o : at least one request is set
module rr_pick
    import arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter bit RR_EN   = 1'b1,
    parameter int IDW     = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDW-1:0]     last_i,
    output logic [IDW-1:0]     win_o,
    output logic               valid_o
);

    logic [2*NUM_REQ-1:0] dbl;
    logic [2*NUM_REQ-1:0] masked;
    int                   start;

    // The request vector is doubled so a search beginning at 'start' can run
    // upward past the top index and wrap into the low requesters without a
    // second encoder. Bits below 'start' in the lower copy are masked off; the
    // upper copy supplies the wrapped-around candidates.
    always_comb begin
        start   = 0;
        dbl     = {req_i, req_i};
        masked  = '0;
        win_o   = '0;
        valid_o = |req_i;
        if (RR_EN) begin
            start = (int'(last_i) + 1) % NUM_REQ;
        end
        for (int i = 0; i < 2 * NUM_REQ; i++) begin
            masked[i] = dbl[i] && (i >= start);
        end
        // Scan high to low so the lowest set position is the final assignment.
        for (int i = 2 * NUM_REQ - 1; i >= 0; i--) begin
            if (masked[i]) begin
                win_o = IDW'((i >= NUM_REQ) ? (i - NUM_REQ) : i);
            end
        end
    end

endmodule

// File: rtl/prio_grant_arbiter.sv
// rtl/prio_grant_arbiter.sv - registered one-hot grant arbiter with hold limit
// Ports:
//   clk   : clock, all state updates on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of prio_grant_arbiter_if (req in; gnt, gnt_id, busy, expire out)
// Parameters: NUM_REQ (2..8), MAX_HOLD (>=1), RR_EN (1 round-robin, 0 fixed, req[0] first)
module prio_grant_arbiter
    import arb_pkg::*;
#(
    parameter int NUM_REQ  = 3,
    parameter int MAX_HOLD = 8,
    parameter bit RR_EN    = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    prio_grant_arbiter_if.slave  bus
);

    localparam int IDW = clog2(NUM_REQ);
    localparam int HW  = clog2(MAX_HOLD + 1);

    state_t             state_q,  state_d;
    logic [NUM_REQ-1:0] gnt_q,    gnt_d;
    logic [IDW-1:0]     gnt_id_q, gnt_id_d;
    logic               expire_q, expire_d;
    logic [HW-1:0]      hold_q,   hold_d;
    logic [IDW-1:0]     last_q,   last_d;

    logic [IDW-1:0]     pick_id;
    logic               pick_valid;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .RR_EN   (RR_EN),
        .IDW     (IDW)
    ) u_pick (
        .req_i   (bus.req),
        .last_i  (last_q),
        .win_o   (pick_id),
        .valid_o (pick_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            expire_q <= 1'b0;
            hold_q   <= '0;
            last_q   <= IDW'(NUM_REQ - 1);
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
            expire_q <= expire_d;
            hold_q   <= hold_d;
            last_q   <= last_d;
        end
    end

    // Arbitration only happens in IDLE, so every release is followed by at
    // least one dead cycle and the pick there already sees the updated 'last'.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        gnt_id_d = gnt_id_q;
        expire_d = 1'b0;
        hold_d   = hold_q;
        last_d   = last_q;
        case (state_q)
            ST_IDLE: begin
                gnt_d  = '0;
                hold_d = '0;
                if (pick_valid) begin
                    state_d  = ST_GRANT;
                    gnt_d    = NUM_REQ'(1) << pick_id;
                    gnt_id_d = pick_id;
                    hold_d   = HW'(1);
                end
            end
            ST_GRANT: begin
                if (!bus.req[gnt_id_q]) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    hold_d  = '0;
                    last_d  = gnt_id_q;
                end else if (hold_q == HW'(MAX_HOLD)) begin
                    // Owner still requesting at the limit: preempt it.
                    state_d  = ST_IDLE;
                    gnt_d    = '0;
                    hold_d   = '0;
                    expire_d = 1'b1;
                    last_d   = gnt_id_q;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                hold_d  = '0;
            end
        endcase
    end

    assign bus.gnt    = gnt_q;
    assign bus.gnt_id = gnt_id_q;
    assign bus.busy   = (state_q == ST_GRANT);
    assign bus.expire = expire_q;

endmodule

// File: tb/tb_prio_grant_arbiter.sv
// tb/tb_prio_grant_arbiter.sv - directed self-checking bench for prio_grant_arbiter
module tb_prio_grant_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    prio_grant_arbiter_if #(.NUM_REQ(3)) if_rr ();
    prio_grant_arbiter_if #(.NUM_REQ(3)) if_fp ();
    prio_grant_arbiter_if #(.NUM_REQ(3)) if_h1 ();

    prio_grant_arbiter #(.NUM_REQ(3), .MAX_HOLD(8), .RR_EN(1'b1)) u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_rr)
    );

    prio_grant_arbiter #(.NUM_REQ(3), .MAX_HOLD(8), .RR_EN(1'b0)) u_fp (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_fp)
    );

    prio_grant_arbiter #(.NUM_REQ(3), .MAX_HOLD(1), .RR_EN(1'b1)) u_h1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_h1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    logic [2:0] h1_exp [0:9];
    logic [2:0] rr_exp;
    logic [2:0] fp_exp;

    initial begin
        h1_exp = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100,
                   3'b000, 3'b001, 3'b000, 3'b010, 3'b000};
        if_rr.req = '0;
        if_fp.req = '0;
        if_h1.req = '0;

        // Reset
        #1 rst_n = 1'b0;
        tick();
        tick();
        chk("rst rr gnt",    32'(if_rr.gnt),    32'h0);
        chk("rst rr gnt_id", 32'(if_rr.gnt_id), 32'h0);
        chk("rst rr busy",   32'(if_rr.busy),   32'h0);
        chk("rst rr expire", 32'(if_rr.expire), 32'h0);
        rst_n = 1'b1;
        tick();
        chk("idle rr gnt", 32'(if_rr.gnt), 32'h0);

        // Hold limit with round-robin, fixed priority re-win, MAX_HOLD=1 rotation
        if_rr.req = 3'b101;
        if_fp.req = 3'b011;
        if_h1.req = 3'b111;
        for (int k = 1; k <= 10; k++) begin
            tick();
            rr_exp = (k <= 8) ? 3'b001 : ((k == 9) ? 3'b000 : 3'b100);
            fp_exp = (k == 9) ? 3'b000 : 3'b001;
            chk($sformatf("A%0d rr gnt", k),    32'(if_rr.gnt),    32'(rr_exp));
            chk($sformatf("A%0d rr expire", k), 32'(if_rr.expire), (k == 9) ? 32'h1 : 32'h0);
            chk($sformatf("A%0d rr busy", k),   32'(if_rr.busy),   (k == 9) ? 32'h0 : 32'h1);
            chk($sformatf("A%0d fp gnt", k),    32'(if_fp.gnt),    32'(fp_exp));
            chk($sformatf("A%0d fp expire", k), 32'(if_fp.expire), (k == 9) ? 32'h1 : 32'h0);
            chk($sformatf("A%0d h1 gnt", k),    32'(if_h1.gnt),    32'(h1_exp[k-1]));
            chk($sformatf("A%0d h1 expire", k), 32'(if_h1.expire), (k % 2 == 0) ? 32'h1 : 32'h0);
        end
        chk("A rr gnt_id after rotate", 32'(if_rr.gnt_id), 32'h2);

        // Normal release: no expire, owner id retained
        if_rr.req = '0;
        if_fp.req = '0;
        if_h1.req = '0;
        tick();
        chk("B rr gnt release",   32'(if_rr.gnt),    32'h0);
        chk("B rr expire normal", 32'(if_rr.expire), 32'h0);
        chk("B rr gnt_id kept",   32'(if_rr.gnt_id), 32'h2);
        tick();

        // Short grant of requester 1, three cycles then dropped
        if_rr.req = 3'b010;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk($sformatf("C%0d rr gnt", k),    32'(if_rr.gnt),    32'h2);
            chk($sformatf("C%0d rr gnt_id", k), 32'(if_rr.gnt_id), 32'h1);
        end
        if_rr.req = '0;
        tick();
        chk("C rr gnt dropped", 32'(if_rr.gnt),    32'h0);
        chk("C rr expire",      32'(if_rr.expire), 32'h0);
        chk("C rr busy",        32'(if_rr.busy),   32'h0);
        chk("C rr gnt_id",      32'(if_rr.gnt_id), 32'h1);
        tick();
        chk("C rr gnt_id idle", 32'(if_rr.gnt_id), 32'h1);

        // Asynchronous reset mid-grant
        if_rr.req = 3'b100;
        tick();
        chk("D rr gnt pre-reset", 32'(if_rr.gnt), 32'h4);
        #2 rst_n = 1'b0;
        #1;
        chk("D rr gnt async clr",  32'(if_rr.gnt),  32'h0);
        chk("D rr busy async clr", 32'(if_rr.busy), 32'h0);
        if_rr.req = 3'b110;
        tick();
        tick();
        chk("D rr gnt in reset", 32'(if_rr.gnt), 32'h0);
        rst_n = 1'b1;
        tick();
        chk("D rr first gnt",    32'(if_rr.gnt),    32'h2);
        chk("D rr first gnt_id", 32'(if_rr.gnt_id), 32'h1);
        if_rr.req = '0;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
